step_control_unit: RTL and testbench

//  Control sequencer that sits directly downstream of the 2-bit step counter of the base processor.
//  - Consumes the counter's step value and latches instructions into an internal IR.
//  - Drives register-file, accumulator and ALU control strobes step by step.
//  - Requests the counter clear on instruction completion and when the counter is out of sync.

---
 rtl/step_control_unit_if.sv | 37 +++
 rtl/step_control_unit.sv | 145 ++++++++++++++
 tb/tb_step_control_unit.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/step_control_unit_if.sv
// Control-path bundle between the step counter, the step control unit and the datapath.
// The master side drives run/instr/step; the slave side (the control unit) drives everything else.
interface step_control_unit_if #(
    parameter int OP_W = 3,
    parameter int RA_W = 3
);
    localparam int IR_W = OP_W + 2 * RA_W;
    localparam int NREG = 1 << RA_W;

    logic            run;
    logic [IR_W-1:0] instr;
    logic [1:0]      step;
    logic            step_clear;
    logic            busy;
    logic            done;
    logic [IR_W-1:0] ir_q;
    logic [NREG-1:0] r_in;
    logic [NREG-1:0] r_out;
    logic            din_out;
    logic            a_in;
    logic            g_in;
    logic            g_out;
    logic            addsub;
    logic            illegal;

    modport master (
        output run, instr, step,
        input  step_clear, busy, done, ir_q, r_in, r_out,
               din_out, a_in, g_in, g_out, addsub, illegal
    );

    modport slave (
        input  run, instr, step,
        output step_clear, busy, done, ir_q, r_in, r_out,
               din_out, a_in, g_in, g_out, addsub, illegal
    );
endinterface

// File: rtl/step_control_unit.sv
// Step sequencer: latches an instruction at T0 and decodes {ir_q, step} into datapath strobes.
// Optional CTRL_ILLEGAL_TRAP_EN makes op 1xx set a sticky illegal flag instead of a silent NOP.
module step_control_unit #(
    parameter int OP_W = 3,
    parameter int RA_W = 3
) (
    input  logic              clock,
    input  logic              clear,
    step_control_unit_if.slave bus
);
    localparam int IR_W = OP_W + 2 * RA_W;
    localparam int NREG = 1 << RA_W;

    localparam logic [OP_W-1:0] OP_MV  = OP_W'(0);
    localparam logic [OP_W-1:0] OP_MVI = OP_W'(1);
    localparam logic [OP_W-1:0] OP_ADD = OP_W'(2);
    localparam logic [OP_W-1:0] OP_SUB = OP_W'(3);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t          state_q, state_d;
    logic [IR_W-1:0] ir_q;
    logic            capture;
    logic            illegal_op;

    logic [OP_W-1:0] op;
    logic [RA_W-1:0] rx, ry;
    logic [NREG-1:0] rx_oh, ry_oh;

    logic            step_clear, done, din_out, a_in, g_in, g_out, addsub;
    logic [NREG-1:0] r_in, r_out;

    assign op    = ir_q[IR_W-1 -: OP_W];
    assign rx    = ir_q[2*RA_W-1 -: RA_W];
    assign ry    = ir_q[RA_W-1:0];
    assign rx_oh = NREG'(1) << rx;
    assign ry_oh = NREG'(1) << ry;
    // Anything outside the four defined opcodes is treated like op 1xx so it can never stall.
    assign illegal_op = (op > OP_SUB);

    always_ff @(posedge clock or posedge clear) begin
        if (clear) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d    = state_q;
        capture    = 1'b0;
        step_clear = 1'b0;
        done       = 1'b0;
        r_in       = '0;
        r_out      = '0;
        din_out    = 1'b0;
        a_in       = 1'b0;
        g_in       = 1'b0;
        g_out      = 1'b0;
        addsub     = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.step == 2'd0 && bus.run) begin
                    capture = 1'b1;
                    state_d = BUSY;
                end else begin
                    step_clear = 1'b1;
                end
            end
            BUSY: begin
                if (bus.step == 2'd0) begin
                    // Counter fell back to T0 mid-instruction: abandon it, keep ir_q.
                    step_clear = 1'b1;
                    state_d    = IDLE;
                end else begin
                    if (illegal_op) begin
                        done = (bus.step == 2'd1);
                    end else begin
                        case (op)
                            OP_MV: if (bus.step == 2'd1) begin
                                r_out = ry_oh;
                                r_in  = rx_oh;
                                done  = 1'b1;
                            end
                            OP_MVI: if (bus.step == 2'd1) begin
                                din_out = 1'b1;
                                r_in    = rx_oh;
                                done    = 1'b1;
                            end
                            default: begin
                                case (bus.step)
                                    2'd1: begin
                                        r_out = rx_oh;
                                        a_in  = 1'b1;
                                    end
                                    2'd2: begin
                                        r_out  = ry_oh;
                                        g_in   = 1'b1;
                                        addsub = (op == OP_SUB);
                                    end
                                    2'd3: begin
                                        g_out = 1'b1;
                                        r_in  = rx_oh;
                                        done  = 1'b1;
                                    end
                                    default: ;
                                endcase
                            end
                        endcase
                    end
                    if (done) begin
                        step_clear = 1'b1;
                        state_d    = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear)        ir_q <= '0;
        else if (capture) ir_q <= bus.instr;
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;
    always_ff @(posedge clock or posedge clear) begin
        if (clear)                                                      illegal_q <= 1'b0;
        else if (state_q == BUSY && bus.step == 2'd1 && illegal_op)     illegal_q <= 1'b1;
    end
    assign bus.illegal = illegal_q;
`else
    assign bus.illegal = 1'b0;
`endif

    assign bus.step_clear = step_clear;
    assign bus.busy       = (state_q == BUSY);
    assign bus.done       = done;
    assign bus.ir_q       = ir_q;
    assign bus.r_in       = r_in;
    assign bus.r_out      = r_out;
    assign bus.din_out    = din_out;
    assign bus.a_in       = a_in;
    assign bus.g_in       = g_in;
    assign bus.g_out      = g_out;
    assign bus.addsub     = addsub;
endmodule

// File: tb/tb_step_control_unit.sv
// Directed bench for step_control_unit: steps are driven by hand, one vector per cycle.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_step_control_unit;
    logic clock = 1'b0;
    logic clear = 1'b1;
    int   errors = 0;
    int   checks = 0;

`ifdef CTRL_ILLEGAL_TRAP_EN
    localparam logic TRAP = 1'b1;
`else
    localparam logic TRAP = 1'b0;
`endif

    step_control_unit_if #(.OP_W(3), .RA_W(3)) bus ();

    step_control_unit #(.OP_W(3), .RA_W(3)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // {r_in, r_out, din_out, a_in, g_in, g_out, addsub, done, step_clear, busy}
    function automatic logic [25:0] obs();
        return {bus.r_in, bus.r_out, bus.din_out, bus.a_in, bus.g_in, bus.g_out,
                bus.addsub, bus.done, bus.step_clear, bus.busy};
    endfunction

    function automatic logic [25:0] ev(input logic [7:0] rin, input logic [7:0] rout,
                                       input logic din, input logic a, input logic gi,
                                       input logic go, input logic as, input logic dn,
                                       input logic sc, input logic bz);
        return {rin, rout, din, a, gi, go, as, dn, sc, bz};
    endfunction

    task automatic drive(input logic [1:0] s, input logic r, input logic [8:0] i);
        @(negedge clock);
        bus.step  = s;
        bus.run   = r;
        bus.instr = i;
        #1;
    endtask

    logic [25:0] e;

    task automatic test_reset();
        bus.step = 2'd2; bus.run = 1'b1; bus.instr = 9'h1ff;
        repeat (2) @(posedge clock);
        @(negedge clock); #1;
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL reset_outputs: got=%h exp=%h", obs(), e); end
        checks++; if (bus.ir_q !== 9'h000) begin errors++; $display("FAIL reset_ir_q: got=%h exp=000", bus.ir_q); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL reset_illegal: got=%b exp=0", bus.illegal); end
        clear = 1'b0;
        drive(2'd2, 1'b1, 9'h1ff);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL out_of_sync_idle: got=%h exp=%h", obs(), e); end
        drive(2'd3, 1'b1, 9'h1ff);
        checks++; if (obs() !== e) begin errors++; $display("FAIL out_of_sync_no_capture: got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_mvi();
        drive(2'd0, 1'b1, 9'b001_011_000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL mvi_t0: got=%h exp=%h", obs(), e); end
        drive(2'd1, 1'b0, 9'h000);
        e = ev(8'h08, 8'h00, 1, 0, 0, 0, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL mvi_t1: got=%h exp=%h", obs(), e); end
        checks++; if (bus.ir_q !== 9'b001_011_000) begin errors++; $display("FAIL mvi_ir_q: got=%h exp=%h", bus.ir_q, 9'b001_011_000); end
        drive(2'd0, 1'b0, 9'h000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL mvi_idle: got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_add();
        drive(2'd0, 1'b1, 9'b010_001_010);
        drive(2'd1, 1'b0, 9'h000);
        e = ev(8'h00, 8'h02, 0, 1, 0, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL add_t1: got=%h exp=%h", obs(), e); end
        drive(2'd2, 1'b0, 9'h000);
        e = ev(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL add_t2: got=%h exp=%h", obs(), e); end
        drive(2'd3, 1'b0, 9'h000);
        e = ev(8'h02, 8'h00, 0, 0, 0, 1, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL add_t3: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b0, 9'h000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL add_idle: got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_run_ignored_while_busy();
        drive(2'd0, 1'b1, 9'b011_010_011);
        drive(2'd1, 1'b0, 9'h000);
        e = ev(8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL sub_t1: got=%h exp=%h", obs(), e); end
        drive(2'd2, 1'b1, 9'b000_111_111);
        e = ev(8'h00, 8'h08, 0, 0, 1, 0, 1, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL sub_t2: got=%h exp=%h", obs(), e); end
        drive(2'd3, 1'b1, 9'b000_111_111);
        checks++; if (bus.ir_q !== 9'b011_010_011) begin errors++; $display("FAIL sub_ir_kept: got=%h exp=%h", bus.ir_q, 9'b011_010_011); end
        e = ev(8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL sub_t3: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b1, 9'b000_111_111);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 0, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL back_to_back_t0: got=%h exp=%h", obs(), e); end
        drive(2'd1, 1'b0, 9'h000);
        checks++; if (bus.ir_q !== 9'b000_111_111) begin errors++; $display("FAIL back_to_back_ir: got=%h exp=%h", bus.ir_q, 9'b000_111_111); end
        e = ev(8'h80, 8'h80, 0, 0, 0, 0, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL mv_same_reg: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b0, 9'h000);
    endtask

    task automatic test_clear_mid();
        drive(2'd0, 1'b1, 9'b010_001_010);
        drive(2'd1, 1'b0, 9'h000);
        drive(2'd2, 1'b0, 9'h000);
        e = ev(8'h00, 8'h04, 0, 0, 1, 0, 0, 0, 0, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL clr_before: got=%h exp=%h", obs(), e); end
        #2 clear = 1'b1;
        #1;
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL clr_immediate: got=%h exp=%h", obs(), e); end
        @(posedge clock);
        #1 clear = 1'b0;
        drive(2'd3, 1'b0, 9'h000);
        checks++; if (obs() !== e) begin errors++; $display("FAIL clr_t3_after: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b0, 9'h000);
        checks++; if (obs() !== e) begin errors++; $display("FAIL clr_no_done: got=%h exp=%h", obs(), e); end
    endtask

    task automatic test_lost_sync();
        drive(2'd0, 1'b1, 9'b000_101_110);
        drive(2'd0, 1'b0, 9'h000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL lost_sync_busy: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b0, 9'h000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 0, 1, 0);
        checks++; if (obs() !== e) begin errors++; $display("FAIL lost_sync_idle: got=%h exp=%h", obs(), e); end
        checks++; if (bus.ir_q !== 9'b000_101_110) begin errors++; $display("FAIL lost_sync_ir: got=%h exp=%h", bus.ir_q, 9'b000_101_110); end
    endtask

    task automatic test_illegal();
        drive(2'd0, 1'b1, 9'b110_000_000);
        drive(2'd1, 1'b0, 9'h000);
        e = ev(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL illegal_t1: got=%h exp=%h", obs(), e); end
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_pre: got=%b exp=0", bus.illegal); end
        drive(2'd0, 1'b0, 9'h000);
        checks++; if (bus.illegal !== TRAP) begin errors++; $display("FAIL illegal_set: got=%b exp=%b", bus.illegal, TRAP); end
        drive(2'd0, 1'b1, 9'b001_000_000);
        drive(2'd1, 1'b0, 9'h000);
        e = ev(8'h01, 8'h00, 1, 0, 0, 0, 0, 1, 1, 1);
        checks++; if (obs() !== e) begin errors++; $display("FAIL mvi_after_illegal: got=%h exp=%h", obs(), e); end
        drive(2'd0, 1'b0, 9'h000);
        checks++; if (bus.illegal !== TRAP) begin errors++; $display("FAIL illegal_sticky: got=%b exp=%b", bus.illegal, TRAP); end
        @(negedge clock);
        clear = 1'b1;
        #1;
        checks++; if (bus.illegal !== 1'b0) begin errors++; $display("FAIL illegal_cleared: got=%b exp=0", bus.illegal); end
        @(negedge clock);
        clear = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mvi();
        test_add();
        test_run_ignored_while_busy();
        test_clear_mid();
        test_lost_sync();
        test_illegal();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
